// File: rtl/aq_axis_djpeg_seq.sv
// Frame sequencer for the JPEG decoder: soft-reset pulse, header wait, pixel count, drain, watchdog.
// Optional decode-duration counter on CYCLE_COUNT is built when AQ_DJPEG_SEQ_CYCLE_CNT_EN is defined.
module aq_axis_djpeg_seq #(
  parameter int RST_CYCLES = 16,
  parameter int TIMEOUT    = 1048576
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        START,
  input  logic        ABORT,
  input  logic        IRQ_CLR,
  output logic        LOGIC_RST,
  input  logic        LOGIC_IDLE,
  input  logic [15:0] WIDTH,
  input  logic [15:0] HEIGHT,
  input  logic        PIX_VALID,
  input  logic        PIX_READY,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic        IRQ,
  output logic [31:0] PIX_COUNT,
  output logic [31:0] CYCLE_COUNT,
  output logic [2:0]  STATE
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RESET = 3'd1, S_HDR = 3'd2, S_RUN = 3'd3, S_DRAIN = 3'd4, S_ERR = 3'd5
  } state_t;

  localparam logic [31:0] RC = 32'(RST_CYCLES - 1);
  localparam logic [31:0] TO = 32'(TIMEOUT);

  state_t      state;
  logic [31:0] expected, wdog, rcnt, pix_inc;
  logic        hs, active, wd_fire, to_err;

  assign STATE   = state;
  assign hs      = PIX_VALID & PIX_READY;
  assign active  = (state == S_HDR) || (state == S_RUN) || (state == S_DRAIN);
  assign pix_inc = (&PIX_COUNT) ? PIX_COUNT : PIX_COUNT + 32'd1;
  // hs clears the watchdog, so a handshake cycle can never time out
  assign wd_fire = (TO != 32'd0) && active && !hs && (wdog + 32'd1 == TO);
  assign to_err  = (active || state == S_RESET) &&
                   (ABORT || wd_fire || (state == S_DRAIN && hs));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= S_IDLE;
      LOGIC_RST <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERROR     <= 1'b0;
      IRQ       <= 1'b0;
      PIX_COUNT <= '0;
      expected  <= '0;
      wdog      <= '0;
      rcnt      <= '0;
    end else begin
      if (IRQ_CLR) IRQ <= 1'b0;
      if (active) begin
        if (hs) begin
          PIX_COUNT <= pix_inc;
          wdog      <= '0;
        end else begin
          wdog <= wdog + 32'd1;
        end
      end
      if (to_err) begin
        state     <= S_ERR;
        ERROR     <= 1'b1;
        IRQ       <= 1'b1;
        LOGIC_RST <= 1'b1;
        rcnt      <= RC;
        wdog      <= '0;
      end else begin
        case (state)
          S_IDLE: if (START) begin
            state     <= S_RESET;
            BUSY      <= 1'b1;
            LOGIC_RST <= 1'b1;
            rcnt      <= RC;
            DONE      <= 1'b0;
            ERROR     <= 1'b0;
            PIX_COUNT <= '0;
          end
          S_RESET: if (rcnt == 32'd0) begin
            state     <= S_HDR;
            LOGIC_RST <= 1'b0;
            wdog      <= '0;
          end else begin
            rcnt <= rcnt - 32'd1;
          end
          S_HDR: if (WIDTH != 16'd0 && HEIGHT != 16'd0 && !LOGIC_IDLE) begin
            expected <= 32'(WIDTH) * 32'(HEIGHT);
            state    <= S_RUN;
            wdog     <= '0;
          end
          S_RUN: if (hs && pix_inc == expected) begin
            state <= S_DRAIN;
            wdog  <= '0;
          end
          S_DRAIN: if (LOGIC_IDLE) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            IRQ   <= 1'b1;
            wdog  <= '0;
          end
          S_ERR: if (rcnt == 32'd0) begin
            state     <= S_IDLE;
            BUSY      <= 1'b0;
            LOGIC_RST <= 1'b0;
          end else begin
            rcnt <= rcnt - 32'd1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef AQ_DJPEG_SEQ_CYCLE_CNT_EN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                        CYCLE_COUNT <= '0;
    else if (state == S_IDLE && START) CYCLE_COUNT <= '0;
    else if (active && !(&CYCLE_COUNT)) CYCLE_COUNT <= CYCLE_COUNT + 32'd1;
  end
`else
  assign CYCLE_COUNT = 32'd0;
`endif
endmodule

// File: tb/tb_aq_axis_djpeg_seq.sv
// Directed bench for aq_axis_djpeg_seq with a phase-level reference model checked every cycle.
module tb_aq_axis_djpeg_seq;
  localparam int RSTC = 4;
  localparam int TO   = 64;

  logic        ACLK, ARESET, START, ABORT, IRQ_CLR, LOGIC_RST, LOGIC_IDLE;
  logic [15:0] WIDTH, HEIGHT;
  logic        PIX_VALID, PIX_READY, BUSY, DONE, ERROR, IRQ;
  logic [31:0] PIX_COUNT, CYCLE_COUNT;
  logic [2:0]  STATE;

  aq_axis_djpeg_seq #(.RST_CYCLES(RSTC), .TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .START(START), .ABORT(ABORT), .IRQ_CLR(IRQ_CLR),
    .LOGIC_RST(LOGIC_RST), .LOGIC_IDLE(LOGIC_IDLE), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .BUSY(BUSY), .DONE(DONE),
    .ERROR(ERROR), .IRQ(IRQ), .PIX_COUNT(PIX_COUNT), .CYCLE_COUNT(CYCLE_COUNT),
    .STATE(STATE));

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;
  int rst_hi = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0..5, pulse cycles remaining, stall cycles since progress
  int      m_ph, m_pulse, m_stall, nph;
  longint  m_pix, m_cyc, m_exp;
  bit      m_done, m_err, m_irq, irq_set, hs_m, working;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m_ph = 0; m_pulse = 0; m_stall = 0; m_pix = 0; m_cyc = 0; m_exp = 0;
      m_done = 0; m_err = 0; m_irq = 0;
    end else begin
      hs_m    = PIX_VALID && PIX_READY;
      working = (m_ph >= 2 && m_ph <= 4);
      nph     = m_ph;
      irq_set = 0;
      if (working) begin
        if (hs_m && m_pix < 64'hFFFF_FFFF) m_pix = m_pix + 1;
        if (m_cyc < 64'hFFFF_FFFF) m_cyc = m_cyc + 1;
        m_stall = hs_m ? 0 : m_stall + 1;
      end
      case (m_ph)
        0: if (START) begin
             nph = 1; m_pulse = RSTC; m_done = 0; m_err = 0; m_pix = 0; m_cyc = 0;
           end
        1: begin m_pulse--; if (m_pulse == 0) nph = 2; end
        2: if (WIDTH != 0 && HEIGHT != 0 && !LOGIC_IDLE) begin
             m_exp = longint'(WIDTH) * longint'(HEIGHT); nph = 3;
           end
        3: if (hs_m && m_pix == m_exp) nph = 4;
        4: if (hs_m) nph = 5;
           else if (LOGIC_IDLE) begin nph = 0; m_done = 1; irq_set = 1; end
        5: begin m_pulse--; if (m_pulse == 0) nph = 0; end
        default: nph = 0;
      endcase
      if (m_ph >= 1 && m_ph <= 4 && (ABORT || (working && TO != 0 && m_stall >= TO))) nph = 5;
      if (nph == 5 && m_ph != 5) begin m_err = 1; irq_set = 1; m_pulse = RSTC; end
      if (nph != m_ph) m_stall = 0;
      m_irq = irq_set ? 1'b1 : (IRQ_CLR ? 1'b0 : m_irq);
      m_ph  = nph;
    end
  end

  always @(negedge ACLK) begin
    if (LOGIC_RST) rst_hi++;
    chk("m_state", STATE, m_ph);
    chk("m_lrst", LOGIC_RST, m_pulse > 0 && (m_ph == 1 || m_ph == 5));
    chk("m_busy", BUSY, m_ph != 0);
    chk("m_done", DONE, m_done);
    chk("m_error", ERROR, m_err);
    chk("m_irq", IRQ, m_irq);
    chk("m_pix", PIX_COUNT, m_pix);
`ifdef AQ_DJPEG_SEQ_CYCLE_CNT_EN
    chk("m_cyc", CYCLE_COUNT, m_cyc);
`else
    chk("m_cyc", CYCLE_COUNT, 0);
`endif
  end

  task automatic tick;
    @(posedge ACLK); #1;
  endtask

  task automatic wait_state(input string nm, input int s, input int budget, output int n);
    n = 0;
    while (STATE != 3'(s) && n < budget) begin tick(); n++; end
    chk(nm, STATE, s);
  endtask

  // START, let the decoder reset, present an 8x2 header, then stream pixels
  task automatic frame_to_run;
    int n;
    WIDTH = 0; HEIGHT = 0; LOGIC_IDLE = 1; rst_hi = 0;
    START = 1; tick(); START = 0;
    wait_state("to_hdr", 2, 20, n);
    WIDTH = 16'd8; HEIGHT = 16'd2; LOGIC_IDLE = 0;
    tick();
    chk("in_run", STATE, 3);
    PIX_VALID = 1; PIX_READY = 1;
  endtask

  int n;

  initial begin
    ARESET = 1; START = 0; ABORT = 0; IRQ_CLR = 0; LOGIC_IDLE = 1;
    WIDTH = 0; HEIGHT = 0; PIX_VALID = 0; PIX_READY = 0;
    #12;
    chk("rst_state", STATE, 0); chk("rst_lrst", LOGIC_RST, 0); chk("rst_busy", BUSY, 0);
    chk("rst_irq", IRQ, 0); chk("rst_pix", PIX_COUNT, 0); chk("rst_cyc", CYCLE_COUNT, 0);
    tick(); ARESET = 0; tick();

    ABORT = 1; tick(); ABORT = 0;
    chk("abort_idle", STATE, 0);

    // 1: normal frame, 20 cycles in HDR+RUN+DRAIN
    frame_to_run();
    chk("t1_rst_len", rst_hi, 4);
    repeat (16) tick();
    chk("t1_drain", STATE, 4); chk("t1_pix16", PIX_COUNT, 16);
    PIX_VALID = 0; tick(); tick();
    chk("t1_busy_pre", BUSY, 1);
    LOGIC_IDLE = 1; tick();
    chk("t1_idle", STATE, 0); chk("t1_busy", BUSY, 0); chk("t1_done", DONE, 1);
    chk("t1_irq", IRQ, 1); chk("t1_err", ERROR, 0); chk("t1_pix", PIX_COUNT, 16);
`ifdef AQ_DJPEG_SEQ_CYCLE_CNT_EN
    chk("t6_cyc20", CYCLE_COUNT, 20);
`else
    chk("t6_cyc0", CYCLE_COUNT, 0);
`endif
    IRQ_CLR = 1; tick(); IRQ_CLR = 0;
    chk("t1_irqclr", IRQ, 0);

    // 2: stall after 5 pixels
    frame_to_run();
    repeat (5) tick();
    PIX_VALID = 0;
    wait_state("t2_err", 5, 100, n);
    chk("t2_wd_cycles", n, 64);
    chk("t2_error", ERROR, 1); chk("t2_irq", IRQ, 1); chk("t2_done", DONE, 0);
    rst_hi = 0;
    wait_state("t2_idle", 0, 20, n);
    chk("t2_rst_len", rst_hi, 4); chk("t2_pix", PIX_COUNT, 5);
    IRQ_CLR = 1; tick(); IRQ_CLR = 0;

    // 3: overrun, 17th handshake in DRAIN
    frame_to_run();
    repeat (17) tick();
    PIX_VALID = 0;
    chk("t3_err", STATE, 5); chk("t3_error", ERROR, 1); chk("t3_pix", PIX_COUNT, 17);
    wait_state("t3_idle", 0, 20, n);
    IRQ_CLR = 1; tick(); IRQ_CLR = 0;

    // 4: abort in RUN, START and ABORT ignored while in ERR
    frame_to_run();
    repeat (3) tick();
    PIX_VALID = 0; ABORT = 1; tick(); ABORT = 0;
    chk("t4_err", STATE, 5);
    START = 1; tick(); START = 0;
    ABORT = 1; tick(); ABORT = 0;
    chk("t4_still_err", STATE, 5);
    wait_state("t4_idle", 0, 4, n);
    chk("t4_pulse_end", n, 2);
    chk("t4_pix", PIX_COUNT, 3); chk("t4_error", ERROR, 1);
    START = 1; tick(); START = 0;
    chk("t4_restart", STATE, 1); chk("t4_errclr", ERROR, 0);
    chk("t4_pixclr", PIX_COUNT, 0); chk("t4_irq_kept", IRQ, 1);
    wait_state("t4_hdr", 2, 20, n);
    ABORT = 1; tick(); ABORT = 0;
    wait_state("t4_idle2", 0, 20, n);
    IRQ_CLR = 1; tick(); IRQ_CLR = 0;

    // 5: DONE entry collides with IRQ_CLR
    frame_to_run();
    repeat (16) tick();
    PIX_VALID = 0; tick();
    LOGIC_IDLE = 1; IRQ_CLR = 1; tick();
    chk("t5_done", DONE, 1); chk("t5_irq_set_wins", IRQ, 1);
    tick(); IRQ_CLR = 0;
    chk("t5_irq_clr", IRQ, 0);

    // async reset mid-frame drops LOGIC_RST without a clock edge
    WIDTH = 0; HEIGHT = 0;
    START = 1; tick(); START = 0; tick();
    chk("ar_lrst_pre", LOGIC_RST, 1);
    ARESET = 1; #1;
    chk("ar_lrst", LOGIC_RST, 0); chk("ar_state", STATE, 0); chk("ar_busy", BUSY, 0);
    tick(); ARESET = 0; tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
